// File: rtl/sw_debounce_irq_ctrl.sv
// Avalon-MM switch/button input controller: 2-flop sync, per-bit debounce,
// selectable edge capture into a W1C sticky register and a maskable level irq.
module sw_debounce_irq_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] deb, deb_d;
  logic [WIDTH-1:0] irq_mask, edgecap;
  logic [WIDTH-1:0] rise, fall, edge_det, clr;
  logic [2:0]       cfg;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [31:0]      rd_mux;
  logic             acc_rd, acc_wr, bypass;

  assign acc_rd = chipselect & read;
  assign acc_wr = chipselect & write;
  assign bypass = cfg[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // deb only moves after DEBOUNCE_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bypass) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise = deb & ~deb_d;
    fall = ~deb & deb_d;
    case (cfg[1:0])
      2'b00:   edge_det = rise;
      2'b01:   edge_det = fall;
      2'b10:   edge_det = rise | fall;
      default: edge_det = '0;
    endcase
  end

  always_comb begin
    clr = '0;
    if (acc_wr && address == 2'd3) clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd2:    rd_mux[2:0]       = cfg;
      default: rd_mux[WIDTH-1:0] = edgecap;
    endcase
  end

  // a new edge overrides a same-cycle W1C of that bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_d    <= '0;
      edgecap  <= '0;
      irq_mask <= '0;
      cfg      <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      deb_d   <= deb;
      edgecap <= (edgecap & ~clr) | edge_det;
      irq     <= |(edgecap & irq_mask);
      if (acc_wr && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
      if (acc_wr && address == 2'd2) cfg <= writedata[2:0];
      readdata <= acc_rd ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// Directed bench for sw_debounce_irq_ctrl with a history-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_sw_debounce_irq_ctrl;
  localparam int W   = 4;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = '0;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic cmp_on = 1'b0;

  sw_debounce_irq_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sync value is the input seen two edges earlier; a bit
  // flips once the last DEB sync samples all disagree with it.
  logic [W-1:0] m_in1, m_in2, m_deb, m_debd, m_ec, m_mask;
  logic [W-1:0] sh [DEB];
  logic [2:0]   m_cfg;
  logic         m_irq;
  logic [31:0]  m_rd;
  logic [W-1:0] t_deb, t_edge, t_clr, t_rise, t_fall;
  logic         t_all;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in1 = '0; m_in2 = '0; m_deb = '0; m_debd = '0; m_ec = '0;
      m_mask = '0; m_cfg = '0; m_irq = 1'b0; m_rd = '0;
      for (int j = 0; j < DEB; j++) sh[j] = '0;
    end else begin
      for (int j = DEB - 1; j > 0; j--) sh[j] = sh[j-1];
      sh[0] = m_in2;
      t_deb = m_deb;
      if (m_cfg[2]) t_deb = m_in2;
      else
        for (int i = 0; i < W; i++) begin
          t_all = 1'b1;
          for (int j = 0; j < DEB; j++) t_all = t_all & (sh[j][i] != m_deb[i]);
          if (t_all) t_deb[i] = ~m_deb[i];
        end
      t_rise = m_deb & ~m_debd;
      t_fall = m_debd & ~m_deb;
      case (m_cfg[1:0])
        2'b00: t_edge = t_rise;
        2'b01: t_edge = t_fall;
        2'b10: t_edge = t_rise | t_fall;
        default: t_edge = '0;
      endcase
      t_clr = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && read)
        case (address)
          2'd0: m_rd = {28'h0, m_deb};
          2'd1: m_rd = {28'h0, m_mask};
          2'd2: m_rd = {29'h0, m_cfg};
          default: m_rd = {28'h0, m_ec};
        endcase
      else m_rd = '0;
      m_irq = |(m_ec & m_mask);
      m_ec  = (m_ec & ~t_clr) | t_edge;
      if (chipselect && write && address == 2'd1) m_mask = writedata[W-1:0];
      if (chipselect && write && address == 2'd2) m_cfg = writedata[2:0];
      m_debd = m_deb;
      m_deb  = t_deb;
      m_in2  = m_in1;
      m_in1  = in_port;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'h0, irq}, {31'h0, m_irq});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk);
    #1;
    check(name, readdata, exp);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #20;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cmp_on = 1'b1;
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h0, "rst_mask");
    rd(2'd2, 32'h0, "rst_cfg");
    rd(2'd3, 32'h0, "rst_edgecap");
    check("rst_irq_after", {31'h0, irq}, 32'h0);

    // debounce latency with a continuous DATA read
    @(negedge clk);
    in_port = 4'b0001;
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("deb_latency", readdata, (k >= 7) ? 32'h1 : 32'h0);
    end
    chipselect = 1'b0; read = 1'b0;

    // 3-cycle glitch on bit1 must be rejected
    @(negedge clk);
    in_port = 4'b0011;
    idle(3);
    in_port = 4'b0001;
    idle(10);
    rd(2'd0, 32'h1, "glitch_data");
    rd(2'd3, 32'h1, "glitch_edgecap");
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "w1c_all");

    // rising edge on bit2 with irq
    wr(2'd1, 32'hF);
    wr(2'd2, 32'h0);
    in_port = 4'b0101;
    idle(10);
    rd(2'd3, 32'h4, "rise_edgecap");
    check("rise_irq", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h4);
    check("w1c_irq_lag", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1;
    check("w1c_irq_clear", {31'h0, irq}, 32'h0);
    rd(2'd3, 32'h0, "w1c_edgecap");

    // falling-only mode
    wr(2'd2, 32'h1);
    in_port = 4'b0100;
    idle(10);
    rd(2'd3, 32'h1, "fall_edgecap");
    wr(2'd3, 32'hF);

    // edges disabled
    wr(2'd2, 32'h3);
    in_port = 4'b1100;
    idle(10);
    in_port = 4'b0100;
    idle(10);
    rd(2'd3, 32'h0, "disabled_edgecap");
    rd(2'd2, 32'h3, "cfg_readback");

    // both edges
    wr(2'd2, 32'h2);
    in_port = 4'b1100;
    idle(10);
    in_port = 4'b0100;
    idle(10);
    rd(2'd3, 32'h8, "both_edgecap");
    wr(2'd3, 32'hF);

    // W1C of bit0 on the same edge that bit0 gets set
    wr(2'd2, 32'h0);
    @(negedge clk);
    in_port = 4'b0101;
    idle(5);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h1, "collision_edgecap");
    check("collision_irq", {31'h0, irq}, 32'h1);
    wr(2'd1, 32'h0);
    check("mask_irq_lag", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1;
    check("mask_irq_clear", {31'h0, irq}, 32'h0);
    rd(2'd3, 32'h1, "mask_edgecap_kept");

    // bypass: deb follows sync directly
    wr(2'd1, 32'hF);
    wr(2'd2, 32'h4);
    in_port = 4'b1010;
    repeat (3) @(posedge clk);
    rd(2'd0, 32'hA, "bypass_data");

    // asynchronous reset in the middle of a debounce
    wr(2'd2, 32'h0);
    in_port = 4'b0101;
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_readdata", readdata, 32'hA);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    reset = 1'b0;
    rd(2'd1, 32'h0, "post_rst_mask");
    rd(2'd2, 32'h0, "post_rst_cfg");
    rd(2'd3, 32'h0, "post_rst_edgecap");
    idle(10);
    rd(2'd0, 32'h5, "post_rst_data");
    rd(2'd3, 32'h5, "post_rst_rise");
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    idle(2);
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
